// File: rtl/risc_pkg.sv
// Shared definitions for the cpu instruction interface: driver FSM states,
// capture record and the opcode fields decoded by cpu and its drivers.
package risc_pkg;

    localparam int WORD_W      = 16;
    localparam int DRV_DEPTH   = 16;
    localparam int DRV_ADDR_W  = 4;
    localparam int DRV_TIMEOUT = 255;
    localparam int WDOG_W      = 8;

    // Instruction fields: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd,
    // [4:3] shift, [2:0] Rm; MOV immediate carries imm8 in [7:0].
    localparam logic [2:0] OP_MOV  = 3'b110;
    localparam logic [2:0] OP_ALU  = 3'b101;
    localparam logic [1:0] MOV_IMM = 2'b10;
    localparam logic [1:0] MOV_REG = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_CMP = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_MVN = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        LEAVE,
        EXEC,
        CAPT,
        DONE,
        ERR
    } drv_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] out;
        logic [2:0]        nvz;
    } capture_t;

    function automatic logic drv_busy(input drv_state_t s);
        return (s == LOAD) || (s == START) || (s == LEAVE) || (s == EXEC) || (s == CAPT);
    endfunction

endpackage

// File: rtl/prog_buffer.sv
// Program store for cpu_driver: synchronous write, combinational read so the
// fetch address chosen in a cycle yields its word in that same cycle.
module prog_buffer
    import risc_pkg::*;
#(
    parameter int DEPTH  = DRV_DEPTH,
    parameter int ADDR_W = DRV_ADDR_W,
    parameter int WIDTH  = WORD_W
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: the array is deliberately left out of reset; a reset port on every
    // word would turn a plain RAM into a wall of flops, and software always
    // writes a program before running it.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cpu_driver.sv
// Host-side initiator for the cpu load/start/wait handshake: steps through a
// small program buffer, one instruction per handshake, and records each result.
module cpu_driver
    import risc_pkg::*;
#(
    parameter int DEPTH   = DRV_DEPTH,
    parameter int ADDR_W  = DRV_ADDR_W,
    parameter int TIMEOUT = DRV_TIMEOUT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [15:0]       prog_data,
    input  logic              start,
    input  logic [ADDR_W:0]   num_instr,
    output logic [15:0]       cpu_in,
    output logic              cpu_load,
    output logic              cpu_s,
    input  logic              cpu_w,
    input  logic [15:0]       cpu_out,
    input  logic              cpu_N,
    input  logic              cpu_V,
    input  logic              cpu_Z,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       last_out,
    output logic [2:0]        last_nvz,
    output logic [ADDR_W:0]   instr_count
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    drv_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic [15:0]       cpu_in_q, cpu_in_d;
    capture_t          last_q, last_d;
    logic              err_q, err_d;

    logic              buf_we;
    logic [ADDR_W-1:0] fetch_addr;
    logic [15:0]       buf_rdata;
    logic [15:0]       fetch_word;
    logic [CNT_W-1:0]  num_clamped;
    logic              wdog_expired;

    assign busy   = drv_busy(state_q);
    assign buf_we = prog_we && !busy;

    // Only IDLE (first word) and CAPT (next word) ever fetch, so the address is
    // derived from the current state rather than from next-state logic.
    assign fetch_addr = (state_q == CAPT) ? pc_q + ADDR_W'(1) : '0;

    prog_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (16)
    ) u_prog_buffer (
        .clk     (clk),
        .we_i    (buf_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (fetch_addr),
        .rdata_o (buf_rdata)
    );

    // A write landing in the same cycle as start must be seen by the first fetch.
    assign fetch_word   = (buf_we && (prog_addr == fetch_addr)) ? prog_data : buf_rdata;
    assign num_clamped  = (num_instr > DEPTH_C) ? DEPTH_C : num_instr;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    always_comb begin
        // NOTE: every next-state value takes its hold value before the case, so
        // no branch can leave one unassigned and infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        num_d    = num_q;
        cnt_d    = cnt_q;
        wdog_d   = wdog_q;
        cpu_in_d = cpu_in_q;
        last_d   = last_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d  = '0;
                    cnt_d = '0;
                    err_d = 1'b0;
                    num_d = num_clamped;
                    if (num_clamped == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = LOAD;
                        cpu_in_d = fetch_word;
                    end
                end
            end
            LOAD: begin
                state_d = START;
            end
            START: begin
                state_d = LEAVE;
                wdog_d  = '0;
            end
            LEAVE: begin
                if (!cpu_w) begin
                    state_d = EXEC;
                    wdog_d  = '0;
                end else if (wdog_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            EXEC: begin
                if (cpu_w) begin
                    state_d = CAPT;
                end else if (wdog_expired) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wdog_d = wdog_q + WDOG_W'(1);
                end
            end
            CAPT: begin
                last_d = capture_t'{out: cpu_out, nvz: {cpu_N, cpu_V, cpu_Z}};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_d == num_q) begin
                    state_d = DONE;
                end else begin
                    pc_d     = pc_q + ADDR_W'(1);
                    state_d  = LOAD;
                    cpu_in_d = fetch_word;
                end
            end
            DONE, ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            num_q    <= '0;
            cnt_q    <= '0;
            wdog_q   <= '0;
            cpu_in_q <= '0;
            last_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            num_q    <= num_d;
            cnt_q    <= cnt_d;
            wdog_q   <= wdog_d;
            cpu_in_q <= cpu_in_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign cpu_in      = cpu_in_q;
    assign cpu_load    = (state_q == LOAD);
    assign cpu_s       = (state_q == START);
    assign done        = (state_q == DONE) || (state_q == ERR);
    assign err         = err_q;
    assign last_out    = last_q.out;
    assign last_nvz    = last_q.nvz;
    assign instr_count = cnt_q;

endmodule
